// File: rtl/add_result_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : add_result_accumulator
// Description : Sums BATCH_N consecutive 4-bit adder results into an ACC_W-bit
//               total with a sticky wrap flag, then holds the total on a
//               valid/ready output until the consumer takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module add_result_accumulator #(
    parameter int ACC_W   = 8,
    parameter int BATCH_N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sum0,
    input  logic             sum1,
    input  logic             sum2,
    input  logic             cout,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);

    typedef enum logic [0:0] {
        S_COLLECT = 1'b0,
        S_HOLD    = 1'b1
    } state_t;

    // Count value at which the next accept completes the batch.
    localparam logic [7:0] c_last_cnt = 8'(BATCH_N - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_run;      // low for the reset cycle, keeps in_ready low until rst_n is seen high
    logic [ACC_W-1:0] r_acc;
    logic [7:0]       r_cnt;
    logic             r_ovf;

    logic [3:0]       w_operand;
    logic [ACC_W:0]   w_sum;
    logic             w_accept;
    logic             w_out_hs;
    logic             w_last;

    assign w_operand = {cout, sum2, sum1, sum0};
    assign w_sum     = {1'b0, r_acc} + (ACC_W+1)'(w_operand);
    assign w_accept  = in_valid & in_ready;
    assign w_out_hs  = out_valid & out_ready;
    assign w_last    = (r_cnt == c_last_cnt);

    // Outputs depend only on registered state, never on the handshake inputs.
    assign in_ready  = (r_state == S_COLLECT) & r_run;
    assign out_valid = (r_state == S_HOLD);
    assign out_acc   = r_acc;
    assign out_ovf   = r_ovf;

    // State register; reset dominates everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_COLLECT;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
        end
    end

    // Next-state decode; clear overrides both the final accept and the out handshake.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_COLLECT;
        end else begin
            case (r_state)
                S_COLLECT: if (w_accept && w_last) w_state_nxt = S_HOLD;
                S_HOLD:    if (w_out_hs)           w_state_nxt = S_COLLECT;
                default:   w_state_nxt = S_COLLECT;
            endcase
        end
    end

    // Accumulator, count and sticky wrap flag; an operand seen with clear is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (clear || w_out_hs) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_sum[ACC_W-1:0];
            r_cnt <= r_cnt + 8'd1;
            r_ovf <= r_ovf | w_sum[ACC_W];
        end
    end

endmodule
`default_nettype wire
